opb_register_simulink2ppc_snap: RTL
===================================

Name: opb_register_simulink2ppc_snap

Overview:
OPB slave that carries data the other way from the ppc2simulink register: fabric-side user logic produces 32-bit words, and PPC software reads them over OPB.
- Supports a free-running track mode and an arm/capture-once snapshot mode.
- Provides a capture counter and status.
- Sits on the OPB bus beside the ppc2simulink registers, with its own base/high address window.

Parameters:
C_BASEADDR, 32'h00000000, first byte address of slave window
C_HIGHADDR, 32'h000000FF, last byte address of slave window
C_OPB_AWIDTH, 32, OPB address width (fixed 32)
C_OPB_DWIDTH, 32, OPB data width (fixed 32)
C_FAMILY, "virtex6", target family string, no functional effect

Ports:
OPB_Clk  in  1  sole clock; all logic, including user side, on this clock
OPB_Rst  in  1  reset, asynchronous, active-high
OPB_ABus  in  [0:31]  byte address, bit 0 = MSB
OPB_BE  in  [0:3]  byte enables, BE[0] -> DBus[0:7]
OPB_DBus  in  [0:31]  write data
OPB_RNW  in  1  1 = read
OPB_select  in  1  transfer request
OPB_seqAddr  in  1  ignored
Sl_DBus  out  [0:31]  read data, zero when not acking
Sl_xferAck  out  1  transfer acknowledge
Sl_errAck  out  1  tied 0
Sl_retry  out  1  tied 0
Sl_toutSup  out  1  tied 0
user_data_in  in  [31:0]  data from fabric
user_data_valid  in  1  qualifies user_data_in
user_armed  out  1  mirror of ARMED status bit
user_capture  out  1  one-cycle pulse on every capture

Behaviour:
- Bit mapping: bus bit i = register bit 31-i, both directions.
- Hit: OPB_select=1 and C_BASEADDR <= OPB_ABus <= C_HIGHADDR.
- Word index = OPB_ABus[28:29]:
  - 0 = DATA (RO)
  - 1 = CTRL/STATUS
  - 2 = TSTAMP (see optional feature)
  - 3 reads 0
- Bus FSM:
  - IDLE: on hit -> ACK.
  - ACK: Sl_xferAck=1 for exactly one cycle; Sl_DBus driven with the selected word if RNW=1, else 0; write side effects occur in this cycle. -> WAIT.
  - WAIT: stay until OPB_select=0, then -> IDLE. This guarantees one ack per select.
- Latency: select in cycle N -> ack and data in cycle N+1. Read data is the register value before the N+1 edge; a capture in the ack cycle is visible on the next read.
- Writes to DATA and index 3 are acked and ignored.
- CTRL write uses only OPB_BE[3] (register bits 7:0); other bytes are ignored. Bits:
  - bit0 ARM: write 1 sets ARMED.
  - bit1 MODE: 0 = track, 1 = snapshot.
  - bit2 CLR: write 1 zeroes COUNT; self-clearing.
- STATUS read:
  - bit0 ARMED
  - bit1 MODE
  - bit2 VALID
  - bits 31:16 COUNT
  - other bits 0
- Capture condition: user_data_valid=1 and (MODE=0 or ARMED=1).
- On capture:
  - DATA <= user_data_in
  - VALID <= 1
  - COUNT <= COUNT+1, 16-bit wrapping (FFFF -> 0000)
  - user_capture=1 for one cycle
  - snapshot mode: ARMED <= 0
- ARM write: sets ARMED and clears VALID.
  - A capture in the same cycle as the ARM write is ignored, since ARMED must already be 1.
- MODE change (written value differs from current): clears ARMED.
- CLR together with a capture in the same cycle: COUNT = 0 (clear wins); DATA still updates.
- Reset: every register and output is 0, including Sl_DBus, Sl_xferAck, user_armed, user_capture, and FSM=IDLE.
  - Reset asserted mid-transfer aborts with no ack.
  - After release, a still-asserted select is treated as a new transfer.

Optional Feature:
- Macro: OPB_SIMULINK2PPC_TSTAMP_EN.
- Defined:
  - Free-running 32-bit cycle counter, reset 0, wraps.
  - Its value is latched into TSTAMP on each capture.
  - Word 2 reads TSTAMP.
- Undefined:
  - No counter logic is built.
  - Word 2 reads 0.

Test Plan:
- Track mode, user_data_valid pulse with 32'hDEADBEEF, then read word 0 -> Sl_DBus = 32'hDEADBEEF and xferAck one cycle after select; read word 1 -> 32'h00010004.
- Snapshot: write CTRL 32'h3 (BE=0001), then valid with 32'h11111111 then 32'h22222222 -> DATA = 32'h11111111, user_capture pulses once, ARMED=0, COUNT=1.
- ARM write in the same cycle as user_data_valid -> no capture; the next valid captures.
- CLR write coinciding with a capture, COUNT previously 5 -> COUNT = 0, DATA updated.
- Select held 6 cycles -> exactly one xferAck; read outside [C_BASEADDR, C_HIGHADDR] -> no ack, Sl_DBus = 0.
- Reset asserted in ACK state -> Sl_xferAck drops immediately (async) and all status reads 0 after release. With TSTAMP_EN, capture at cycle 100 after reset -> word 2 reads 100.

Source files
------------

// File: rtl/opb_register_simulink2ppc_snap.sv
// rtl/opb_register_simulink2ppc_snap.sv - OPB read-back register fed from fabric, track or arm/snapshot capture
// Optional build macro: OPB_SIMULINK2PPC_TSTAMP_EN (adds a cycle counter latched on every capture, read as word 2)
module opb_register_simulink2ppc_snap #(
    parameter logic [31:0] C_BASEADDR   = 32'h00000000,
    parameter logic [31:0] C_HIGHADDR   = 32'h000000FF,
    parameter int          C_OPB_AWIDTH = 32,
    parameter int          C_OPB_DWIDTH = 32,
    parameter              C_FAMILY     = "virtex6"
) (
    input  logic                      OPB_Clk,
    input  logic                      OPB_Rst,
    input  logic [0:C_OPB_AWIDTH-1]   OPB_ABus,
    input  logic [0:3]                OPB_BE,
    input  logic [0:C_OPB_DWIDTH-1]   OPB_DBus,
    input  logic                      OPB_RNW,
    input  logic                      OPB_select,
    input  logic                      OPB_seqAddr,
    output logic [0:C_OPB_DWIDTH-1]   Sl_DBus,
    output logic                      Sl_xferAck,
    output logic                      Sl_errAck,
    output logic                      Sl_retry,
    output logic                      Sl_toutSup,
    input  logic [31:0]               user_data_in,
    input  logic                      user_data_valid,
    output logic                      user_armed,
    output logic                      user_capture
);

    typedef enum logic [1:0] {S_IDLE, S_ACK, S_WAIT} state_t;

    state_t      state;
    logic [31:0] addr;
    logic [31:0] offset;
    logic [1:0]  word_idx;
    logic        hit;
    logic        ctrl_wr;
    logic        ctrl_arm;
    logic        ctrl_mode;
    logic        ctrl_clr;
    logic        capture;
    logic [31:0] data_q;
    logic [15:0] count_q;
    logic        armed_q;
    logic        mode_q;
    logic        valid_q;
    logic [31:0] tstamp_word;
    logic [31:0] rd_word;
    logic        unused_bits;

    // Bus bit 0 is the MSB, so a plain vector assignment gives register bit 31-i
    assign addr     = OPB_ABus;
    assign word_idx = addr[3:2];
    // Offset compare handles a window starting at zero without a constant compare
    assign offset   = addr - C_BASEADDR;
    assign hit      = OPB_select && (offset <= (C_HIGHADDR - C_BASEADDR));

    // Only the low byte of CTRL is writable
    assign ctrl_wr   = (state == S_ACK) && !OPB_RNW && (word_idx == 2'd1) && OPB_BE[3];
    assign ctrl_arm  = OPB_DBus[31];
    assign ctrl_mode = OPB_DBus[30];
    assign ctrl_clr  = OPB_DBus[29];

    // Snapshot mode needs ARMED already set, so an ARM write cannot capture in its own cycle
    assign capture = user_data_valid && (!mode_q || armed_q);

    assign Sl_errAck  = 1'b0;
    assign Sl_retry   = 1'b0;
    assign Sl_toutSup = 1'b0;
    assign user_armed = armed_q;

    // Family string and the ignored bus bits have no functional effect
    assign unused_bits = ^{OPB_seqAddr, OPB_BE[0:2], OPB_DBus[0:28], C_FAMILY};

`ifdef OPB_SIMULINK2PPC_TSTAMP_EN
    logic [31:0] cycle_q;
    logic [31:0] tstamp_q;

    // Free-running cycle counter, sampled into TSTAMP whenever a word is captured
    always_ff @(posedge OPB_Clk or posedge OPB_Rst) begin
        if (OPB_Rst) begin
            cycle_q  <= 32'd0;
            tstamp_q <= 32'd0;
        end else begin
            cycle_q <= cycle_q + 32'd1;
            if (capture) begin
                tstamp_q <= cycle_q;
            end
        end
    end

    assign tstamp_word = tstamp_q;
`else
    assign tstamp_word = 32'd0;
`endif

    // Read mux over the four word slots
    always_comb begin
        rd_word = 32'd0;
        case (word_idx)
            2'd0:    rd_word = data_q;
            2'd1:    rd_word = {count_q, 13'd0, valid_q, mode_q, armed_q};
            2'd2:    rd_word = tstamp_word;
            default: rd_word = 32'd0;
        endcase
    end

    // Bus handshake: one ack per select, read data registered with the ack
    always_ff @(posedge OPB_Clk or posedge OPB_Rst) begin
        if (OPB_Rst) begin
            state      <= S_IDLE;
            Sl_xferAck <= 1'b0;
            Sl_DBus    <= '0;
        end else begin
            Sl_xferAck <= 1'b0;
            Sl_DBus    <= '0;
            case (state)
                S_IDLE: begin
                    if (hit) begin
                        state      <= S_ACK;
                        Sl_xferAck <= 1'b1;
                        if (OPB_RNW) begin
                            Sl_DBus <= rd_word;
                        end
                    end
                end
                S_ACK:   state <= S_WAIT;
                S_WAIT:  if (!OPB_select) state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

    // Capture and control state; control writes are applied after capture so ARM wins over snapshot disarm
    always_ff @(posedge OPB_Clk or posedge OPB_Rst) begin
        if (OPB_Rst) begin
            data_q       <= 32'd0;
            count_q      <= 16'd0;
            armed_q      <= 1'b0;
            mode_q       <= 1'b0;
            valid_q      <= 1'b0;
            user_capture <= 1'b0;
        end else begin
            user_capture <= capture;
            if (capture) begin
                data_q  <= user_data_in;
                count_q <= count_q + 16'd1;
                valid_q <= 1'b1;
                if (mode_q) begin
                    armed_q <= 1'b0;
                end
            end
            if (ctrl_wr) begin
                if (ctrl_mode != mode_q) begin
                    armed_q <= 1'b0;
                end
                mode_q <= ctrl_mode;
                if (ctrl_arm) begin
                    armed_q <= 1'b1;
                    if (!capture) begin
                        valid_q <= 1'b0;
                    end
                end
                if (ctrl_clr) begin
                    count_q <= 16'd0;
                end
            end
        end
    end

endmodule
